mem_arbiter: RTL and testbench

//  Shares the single-port 32x8 data memory between two requesters: port 0 (instruction fetch, read-only)
//  and port 1 (load/store, read/write). Arbitrates round-robin, latches the winning request, drives the

---
 rtl/mem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 12 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_pkg;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       vld
);
  always_comb begin
    vld = |req;
    gnt = (&req) ? ~last_gnt : req[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port (0) and a load/store port (1).
// Each grant runs IDLE -> ACCESS -> DONE; ack pulses in DONE.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);
  arb_state_t        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              arb_gnt, arb_vld;

  rr_arb2 u_arb (
    .req      ({p1_req, p0_req}),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .vld      (arb_vld)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d    = ACCESS;
          gnt_d      = arb_gnt;
          last_gnt_d = arb_gnt;
          // port 0 is fetch-only, so its grant can never carry a write
          we_d       = arb_gnt & p1_we;
          addr_d     = arb_gnt ? p1_addr : p0_addr;
          wdata_d    = arb_gnt ? p1_wdata : '0;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q) begin
          if (gnt_q) p1_rdata_d = mem_dout;
          else       p0_rdata_d = mem_dout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Memory strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    mem_re   = (state_q == ACCESS) & ~we_q;
    mem_we   = (state_q == ACCESS) &  we_q;
    mem_addr = (state_q == ACCESS) ? addr_q : '0;
    mem_din  = mem_we ? wdata_q : '0;
    p0_ack   = (state_q == DONE) & ~gnt_q;
    p1_ack   = (state_q == DONE) &  gnt_q;
    busy     = (state_q != IDLE);
    p0_rdata = p0_rdata_q;
    p1_rdata = p1_rdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural 32x8 memory, ack scoreboard, protocol monitor.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p1_req, p1_we;
  logic [4:0] p0_addr, p1_addr;
  logic [7:0] p1_wdata;
  logic       p0_ack, p1_ack;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_re, mem_we, busy;
  logic [4:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  logic [7:0] mem [32] = '{default: 8'h00};

  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } sb_t;
  sb_t sbq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic p0_ack_prev = 1'b0;
  logic p1_ack_prev = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Non-read cycles return a junk pattern so an unqualified sample shows up in rdata.
  assign mem_dout = mem_re ? mem[mem_addr] : 8'hEE;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      chk("re_we_excl", {31'b0, mem_re & mem_we}, 0);
      chk("ack_excl", {31'b0, p0_ack & p1_ack}, 0);
      chk("p0_ack_width", {31'b0, p0_ack & p0_ack_prev}, 0);
      chk("p1_ack_width", {31'b0, p1_ack & p1_ack_prev}, 0);
      if (mem_we) chk("p0_never_writes", {31'b0, p1_req & p1_we}, 1);
      if (p0_ack || p1_ack) begin
        if (sbq.size() == 0) chk("spurious_ack", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("ack_port", {31'b0, p1_ack}, e.port);
          if (e.rd) chk("rdata", e.port != 0 ? p1_rdata : p0_rdata, e.data);
        end
      end
    end
    p0_ack_prev = p0_ack;
    p1_ack_prev = p1_ack;
  end

  // Called just after a rising edge with the arbiter idle; returns just after the edge following ack.
  task automatic access(input int port, input bit we, input logic [4:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    sb_t e;
    int  k;
    bit  got;
    e.port = port; e.rd = !we; e.data = exp_rd;
    sbq.push_back(e);
    if (port == 0) begin
      p0_req = 1'b1; p0_addr = a;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd;
    end
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = (port != 0) ? p1_ack : p0_ack;
    end
    chk("ack_seen", {31'b0, got}, 1);
    chk("latency", k, 3);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_re"}, {31'b0, mem_re}, 0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 0);
    chk({tag, "_mem_addr"}, {27'b0, mem_addr}, 0);
    chk({tag, "_mem_din"}, {24'b0, mem_din}, 0);
    chk({tag, "_acks"}, {30'b0, p1_ack, p0_ack}, 0);
    chk({tag, "_p0_rdata"}, {24'b0, p0_rdata}, 0);
    chk({tag, "_p1_rdata"}, {24'b0, p1_rdata}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    int n, k, last;
    rst = 1'b1;
    p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    #2 chk_zero_outputs("por");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    access(1, 1, 5'd5, 8'hA5, 8'h00);
    access(0, 0, 5'd5, 8'h00, 8'hA5);
    access(1, 1, 5'd6, 8'h5A, 8'h00);
    chk("p0_rdata_held", {24'b0, p0_rdata}, 8'hA5);

    access(1, 1, 5'd31, 8'hFF, 8'h00);
    access(1, 1, 5'd0,  8'h01, 8'h00);
    access(0, 0, 5'd31, 8'h00, 8'hFF);
    access(1, 0, 5'd0,  8'h00, 8'h01);
    access(0, 0, 5'd0,  8'h00, 8'h01);
    access(1, 0, 5'd31, 8'h00, 8'hFF);

    access(1, 1, 5'd3, 8'h33, 8'h00);
    access(1, 1, 5'd4, 8'h44, 8'h00);

    // Abort a write mid-access; p0/p1 rdata are nonzero here so reset clearing is visible.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd7; p1_wdata = 8'h3C;
    @(posedge clk); #1;
    chk("abort_in_access", {31'b0, mem_we}, 1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    p1_req = 1'b0; p1_we = 1'b0;
    sbq.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Both held continuously: expect 0,1,0,1 with acks exactly 3 cycles apart.
    for (int i = 0; i < 2; i++) begin
      sb_t e;
      e.port = 0; e.rd = 1; e.data = 8'h33; sbq.push_back(e);
      e.port = 1; e.rd = 1; e.data = 8'h44; sbq.push_back(e);
    end
    p0_req = 1'b1; p0_addr = 5'd3;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 5'd4;
    n = 0; k = 0; last = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (p0_ack || p1_ack) begin
        if (n == 0) chk("alt_first_latency", k, 3);
        else        chk("alt_spacing", cyc - last, 3);
        last = cyc;
        n++;
      end
    end
    chk("alt_ack_count", n, 4);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 5'd7, 8'h00, 8'h00);
    access(0, 0, 5'd6, 8'h00, 8'h5A);
    chk("sb_drained", sbq.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
